// File: rtl/dmem_channel_arbiter.sv
// rtl/dmem_channel_arbiter.sv - round-robin arbiter serialising data-memory channels onto one external req/ack bus
module dmem_channel_arbiter #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int NUM_CHANNELS   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           ch_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_read_address,
    output logic [NUM_CHANNELS-1:0]           ch_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data,
    input  logic [NUM_CHANNELS-1:0]           ch_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_write_data,
    output logic [NUM_CHANNELS-1:0]           ch_write_ready,
    output logic                              ext_req,
    output logic                              ext_we,
    output logic [ADDR_BITS-1:0]              ext_addr,
    output logic [DATA_BITS-1:0]              ext_wdata,
    input  logic                              ext_ack,
    input  logic [DATA_BITS-1:0]              ext_rdata,
    output logic                              timeout_error
);

    localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]              state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        chan;
    logic [NUM_CHANNELS-1:0] cooldown;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    pick_found;
    logic [PTR_W-1:0]        pick;

    assign eligible = (ch_read_valid | ch_write_valid) & ~cooldown;

    // Two passes: channels at/after rr_ptr first, then the wrapped-around ones.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (!pick_found && eligible[c] && (c >= int'(rr_ptr))) begin
                pick_found = 1'b1;
                pick       = PTR_W'(c);
            end
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (!pick_found && eligible[c]) begin
                pick_found = 1'b1;
                pick       = PTR_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            chan           <= '0;
            cooldown       <= '0;
            wait_cnt       <= '0;
            ch_read_ready  <= '0;
            ch_write_ready <= '0;
            ch_read_data   <= '0;
            ext_req        <= 1'b0;
            ext_we         <= 1'b0;
            ext_addr       <= '0;
            ext_wdata      <= '0;
            timeout_error  <= 1'b0;
        end else begin
            ch_read_ready  <= '0;
            ch_write_ready <= '0;
            case (state)
                IDLE: begin
                    cooldown <= '0;
                    if (pick_found) begin
                        chan      <= pick;
                        ext_we    <= !ch_read_valid[pick];
                        ext_addr  <= ch_read_valid[pick]
                                     ? ch_read_address[pick*ADDR_BITS +: ADDR_BITS]
                                     : ch_write_address[pick*ADDR_BITS +: ADDR_BITS];
                        ext_wdata <= ch_write_data[pick*DATA_BITS +: DATA_BITS];
                        ext_req   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ext_ack || (wait_cnt == CNT_LAST)) begin
                        ext_req <= 1'b0;
                        state   <= RESPOND;
                        if (ext_we) begin
                            ch_write_ready[chan] <= 1'b1;
                        end else begin
                            ch_read_ready[chan] <= 1'b1;
                            ch_read_data[chan*DATA_BITS +: DATA_BITS] <= ext_ack ? ext_rdata : '0;
                        end
                        if (!ext_ack) begin
                            timeout_error <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    // Upstream still shows valid during the next cycle; mask it once.
                    rr_ptr   <= (chan == LAST_CH) ? '0 : chan + 1'b1;
                    cooldown <= NUM_CHANNELS'(1) << chan;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
